// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: four-requester round-robin arbiter in front of a single 8-bit
// Wishbone-style master port.
//
// Ports
//   clk, rst                   system clock, synchronous active-high reset
//   req_cs[3:0]                per-requester request (bit n = requester n)
//   req_we[3:0]                per-requester write enable (1 = write)
//   req_addr[31:0]             packed addresses, requester n at [8n+7:8n]
//   req_din[31:0]              packed write data, same packing
//   req_dout[7:0]              shared read data, held until the next successful read
//   req_ack[3:0], req_err[3:0] one-cycle completion / timeout pulses
//   grant[3:0]                 one-hot owner while a cycle is in progress, else 0
//   wb_stbo, wb_adro, wb_rwo,
//   wb_dato                    master strobe, address, direction (1 = write), write data
//   wb_acki, wb_dati           slave acknowledge and read data
//
// Configuration
//   WB_ARB_TIMEOUT_EN  defined: a wait-cycle budget of TIMEOUT is loaded at grant
//                      and an unacknowledged cycle is completed with req_err.
//                      undefined: no timer; BUSY waits for wb_acki indefinitely.
module wb_rr_arbiter #(
  parameter logic [3:0] TIMEOUT = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_cs,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_din,
  output logic [7:0]  req_dout,
  output logic [3:0]  req_ack,
  output logic [3:0]  req_err,
  output logic [3:0]  grant,
  output logic        wb_stbo,
  output logic [7:0]  wb_adro,
  output logic        wb_rwo,
  output logic [7:0]  wb_dato,
  input  logic        wb_acki,
  input  logic [7:0]  wb_dati
);

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  state_e     state;
  logic [1:0] last;     // most recently served requester
  logic [1:0] winner;   // requester owning the current cycle
  logic [1:0] pick;
  logic       pick_valid;
  logic [1:0] offs;

`ifdef WB_ARB_TIMEOUT_EN
  logic [3:0] timer;
`else
  logic       unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Round-robin search starting at last+1. Walking the offsets from farthest to
  // nearest lets the nearest requesting slot overwrite the others.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    offs       = '0;
    for (int i = 3; i >= 0; i--) begin
      offs = last + 2'd1 + 2'(i);
      if (req_cs[offs]) begin
        pick       = offs;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      wb_stbo  <= 1'b0;
      wb_adro  <= '0;
      wb_rwo   <= 1'b1;
      wb_dato  <= '0;
      req_dout <= '0;
      req_ack  <= '0;
      req_err  <= '0;
      grant    <= '0;
      last     <= 2'd3;
      winner   <= 2'd0;
`ifdef WB_ARB_TIMEOUT_EN
      timer    <= '0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (pick_valid) begin
            winner  <= pick;
            grant   <= 4'b0001 << pick;
            wb_adro <= req_addr[{pick, 3'b000} +: 8];
            wb_dato <= req_din[{pick, 3'b000} +: 8];
            wb_rwo  <= req_we[pick];
            wb_stbo <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            timer   <= TIMEOUT;
`endif
            state   <= StBusy;
          end
        end
        StBusy: begin
          // An ack always wins over an expiring budget.
          if (wb_acki) begin
            wb_stbo         <= 1'b0;
            grant           <= '0;
            req_ack[winner] <= 1'b1;
            last            <= winner;
            state           <= StHold;
            if (!wb_rwo) begin
              req_dout <= wb_dati;
            end
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (timer == 4'd0) begin
            wb_stbo         <= 1'b0;
            grant           <= '0;
            req_ack[winner] <= 1'b1;
            req_err[winner] <= 1'b1;
            last            <= winner;
            state           <= StHold;
          end else begin
            timer <= timer - 4'd1;
          end
`endif
        end
        StHold: begin
          // Gap cycle so the served requester can drop req_cs before re-arbitration.
          req_ack <= '0;
          req_err <= '0;
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam logic [3:0] TIMEOUT = 4'hF;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_cs, req_we;
  logic [31:0] req_addr, req_din;
  logic [7:0]  req_dout;
  logic [3:0]  req_ack, req_err, grant;
  logic        wb_stbo, wb_rwo, wb_acki;
  logic [7:0]  wb_adro, wb_dato, wb_dati;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_cs   (req_cs),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_din  (req_din),
    .req_dout (req_dout),
    .req_ack  (req_ack),
    .req_err  (req_err),
    .grant    (grant),
    .wb_stbo  (wb_stbo),
    .wb_adro  (wb_adro),
    .wb_rwo   (wb_rwo),
    .wb_dato  (wb_dato),
    .wb_acki  (wb_acki),
    .wb_dati  (wb_dati)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: transaction phases 0 idle, 1 busy, 2 hold; m_age counts
  // busy cycles since the grant (1 = first).
  function automatic int rr_pick(input int last_srv, input logic [3:0] cs);
    for (int k = 1; k <= 4; k++) begin
      if (cs[(last_srv + k) % 4]) return (last_srv + k) % 4;
    end
    return -1;
  endfunction

  int m_phase = 0, m_owner = 0, m_last = 3, m_age = 0, m_pick;
  logic       m_stbo, m_rwo;
  logic [7:0] m_adro, m_dato, m_dout;
  logic [3:0] m_ack, m_err, m_grant;

  always_comb m_pick = rr_pick(m_last, req_cs);

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;    m_stbo <= 1'b0; m_adro <= 8'h00; m_rwo  <= 1'b1;
      m_dato  <= 8'h00; m_dout <= 8'h00; m_ack <= 4'h0;  m_err  <= 4'h0;
      m_grant <= 4'h0; m_last <= 3;    m_age  <= 0;
    end else begin
      case (m_phase)
        0: if (m_pick >= 0) begin
          m_owner <= m_pick;
          m_grant <= 4'(1 << m_pick);
          m_adro  <= req_addr[8*m_pick +: 8];
          m_dato  <= req_din[8*m_pick +: 8];
          m_rwo   <= req_we[m_pick];
          m_stbo  <= 1'b1;
          m_age   <= 1;
          m_phase <= 1;
        end
        1: begin
          if (wb_acki || (TIMEOUT_ON && m_age == int'(TIMEOUT) + 1)) begin
            m_stbo  <= 1'b0;
            m_grant <= 4'h0;
            m_last  <= m_owner;
            m_ack   <= 4'(1 << m_owner);
            m_phase <= 2;
            if (!wb_acki) m_err <= 4'(1 << m_owner);
            else if (!m_rwo) m_dout <= wb_dati;
          end else begin
            m_age <= m_age + 1;
          end
        end
        default: begin
          m_ack   <= 4'h0;
          m_err   <= 4'h0;
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_stbo", wb_stbo, m_stbo);
      check("wb_adro", wb_adro, m_adro);
      check("wb_rwo", wb_rwo, m_rwo);
      check("wb_dato", wb_dato, m_dato);
      check("req_dout", req_dout, m_dout);
      check("req_ack", req_ack, m_ack);
      check("req_err", req_err, m_err);
      check("grant", grant, m_grant);
    end
  end

  // One transaction from requester n; the slave acks on the ack_at-th strobe
  // cycle (0 = never). req_cs is dropped after the grant, and a stray ack is
  // driven during the HOLD cycle.
  task automatic run_txn(input int n, input logic we, input logic [7:0] a, input logic [7:0] d,
                         input int ack_at, input logic [7:0] dati, output int hi,
                         output logic [3:0] g, output logic [3:0] ack_seen,
                         output logic [3:0] err_seen);
    req_cs = 4'(1 << n);
    req_we[n] = we;
    req_addr[8*n +: 8] = a;
    req_din[8*n +: 8] = d;
    hi = 0; g = 4'h0; ack_seen = 4'h0; err_seen = 4'h0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      wb_acki = 1'b0;
      if (wb_stbo) begin
        hi++;
        if (hi == 1) begin
          g = grant;
          req_cs = 4'h0;
        end
        if (hi == ack_at) begin
          wb_acki = 1'b1;
          wb_dati = dati;
        end
      end
      if (req_ack != 4'h0 || req_err != 4'h0) begin
        ack_seen = req_ack;
        err_seen = req_err;
        break;
      end
    end
    check("txn_done", 32'(|(ack_seen | err_seen)), 32'd1);
    req_cs = 4'h0;
    wb_acki = 1'b1;
    @(negedge clk);
    wb_acki = 1'b0;
  endtask

  int hi;
  logic [3:0] g, ack, err;
  logic [3:0] rr_exp [5];

  initial begin
    rst = 1'b1; req_cs = 4'h0; req_we = 4'h0; req_addr = '0; req_din = '0;
    wb_acki = 1'b0; wb_dati = 8'h00;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_rwo", wb_rwo, 1);
    check("rst_stbo", wb_stbo, 0);
    check("rst_grant", grant, 0);
    check("rst_dout", req_dout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Requester 2 read, ack on the 3rd strobe cycle.
    run_txn(2, 1'b0, 8'h40, 8'h00, 3, 8'hA5, hi, g, ack, err);
    check("rd2_stbo_cycles", hi, 3);
    check("rd2_grant", g, 4'b0100);
    check("rd2_ack", ack, 4'b0100);
    check("rd2_err", err, 4'b0000);
    check("rd2_dout", req_dout, 8'hA5);

    // Requester 1 write; master-side fields hold afterwards, read data untouched.
    run_txn(1, 1'b1, 8'h10, 8'h3C, 2, 8'hEE, hi, g, ack, err);
    check("wr1_grant", g, 4'b0010);
    check("wr1_ack", ack, 4'b0010);
    check("wr1_rwo", wb_rwo, 1);
    check("wr1_adro", wb_adro, 8'h10);
    check("wr1_dato", wb_dato, 8'h3C);
    check("wr1_dout", req_dout, 8'hA5);

    // Ack in the cycle the budget reaches zero counts as success.
    run_txn(3, 1'b0, 8'h7F, 8'h00, 16, 8'h77, hi, g, ack, err);
    check("edge_stbo_cycles", hi, 16);
    check("edge_ack", ack, 4'b1000);
    check("edge_err", err, 4'b0000);
    check("edge_dout", req_dout, 8'h77);

`ifdef WB_ARB_TIMEOUT_EN
    run_txn(0, 1'b0, 8'h20, 8'h00, 0, 8'h99, hi, g, ack, err);
    check("to_stbo_cycles", hi, 16);
    check("to_ack", ack, 4'b0001);
    check("to_err", err, 4'b0001);
    check("to_dout", req_dout, 8'h77);
`else
    run_txn(0, 1'b0, 8'h20, 8'h00, 21, 8'h99, hi, g, ack, err);
    check("noto_stbo_cycles", hi, 21);
    check("noto_ack", ack, 4'b0001);
    check("noto_err", err, 4'b0000);
    check("noto_dout", req_dout, 8'h99);
`endif

    // Reset in the second busy cycle.
    req_cs = 4'b0010;
    req_we[1] = 1'b0;
    @(negedge clk);
    check("rb_busy1", wb_stbo, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rb_stbo", wb_stbo, 0);
    check("rb_ack", req_ack, 0);
    check("rb_err", req_err, 0);
    check("rb_grant", grant, 0);
    check("rb_rwo", wb_rwo, 1);
    check("rb_adro", wb_adro, 0);
    check("rb_dout", req_dout, 0);
    rst = 1'b0;

    // All four requesting: rotation starts at 0 after reset.
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    req_cs = 4'hF;
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 10; w++) begin
        @(negedge clk);
        if (wb_stbo) break;
      end
      check("rr_stbo", wb_stbo, 1);
      check("rr_grant", grant, rr_exp[k]);
      wb_acki = 1'b1;
      @(negedge clk);
      wb_acki = 1'b0;
      check("rr_ack", req_ack, rr_exp[k]);
      check("rr_hold_gap", wb_stbo, 0);
    end
    req_cs = 4'h0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
